// File: rtl/sdp_y_core_chn_out_rsco_tx.sv
// Two-entry output skid FIFO between the SDP Y core and the chn_out channel.
// Optional consumer-stall counter port enabled by SDP_Y_CHN_OUT_STALL_CNT_EN.
module sdp_y_core_chn_out_rsco_tx (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         chn_out_rsco_oswt,
  input  logic [127:0] chn_out_rsco_d,
  output logic         chn_out_rsco_wen_comp,
  output logic         chn_out_pvld,
  input  logic         chn_out_prdy,
  output logic [127:0] chn_out_pd,
  output logic         chn_out_rsco_bawt
`ifdef SDP_Y_CHN_OUT_STALL_CNT_EN
  ,
  output logic [31:0]  chn_out_stall_cnt
`endif
);

  // State encoding doubles as the occupancy count (0..2).
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0][127:0] mem_q, mem_d;
  logic              push, pop;

  // Space is judged from registered state only, so a pop never frees a slot
  // for the same cycle and there is no prdy -> bawt path.
  assign chn_out_rsco_bawt     = (state_q != FULL);
  assign chn_out_pvld          = (state_q != EMPTY);
  assign chn_out_pd            = mem_q[rd_ptr_q];
  assign chn_out_rsco_wen_comp = ~chn_out_rsco_oswt | chn_out_rsco_bawt;
  assign push                  = chn_out_rsco_oswt & chn_out_rsco_bawt;
  assign pop                   = chn_out_pvld & chn_out_prdy;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = chn_out_rsco_d;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q  <= EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      mem_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mem_q    <= mem_d;
    end
  end

`ifdef SDP_Y_CHN_OUT_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (chn_out_pvld && !chn_out_prdy && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) stall_cnt_q <= '0;
    else                  stall_cnt_q <= stall_cnt_d;
  end

  assign chn_out_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sdp_y_core_chn_out_rsco_tx.sv
// Bench for sdp_y_core_chn_out_rsco_tx: queue-based reference model with a
// per-cycle compare process, directed scenarios and a randomized run.
module tb_sdp_y_core_chn_out_rsco_tx;

  logic         clk = 1'b0;
  logic         rstn;
  logic         oswt;
  logic [127:0] din;
  logic         wen_comp;
  logic         pvld;
  logic         prdy;
  logic [127:0] pd;
  logic         bawt;
`ifdef SDP_Y_CHN_OUT_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sdp_y_core_chn_out_rsco_tx dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rstn       (rstn),
    .chn_out_rsco_oswt     (oswt),
    .chn_out_rsco_d        (din),
    .chn_out_rsco_wen_comp (wen_comp),
    .chn_out_pvld          (pvld),
    .chn_out_prdy          (prdy),
    .chn_out_pd            (pd),
    .chn_out_rsco_bawt     (bawt)
`ifdef SDP_Y_CHN_OUT_STALL_CNT_EN
    ,
    .chn_out_stall_cnt     (stall_cnt)
`endif
  );

  // Reference model: a queue of words in flight, capacity 2.
  logic [127:0] mq[$];
  longint unsigned m_stall;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_stall = 0;
    end else begin
      automatic bit can_take = (mq.size() < 2);
      automatic bit do_pop   = (mq.size() > 0) && prdy;
      if (mq.size() > 0 && !prdy && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (do_pop) void'(mq.pop_front());
      if (oswt && can_take) mq.push_back(din);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_pvld", {127'd0, pvld}, 128'd0);
      chk("rst_bawt", {127'd0, bawt}, 128'd1);
      chk("rst_pd", pd, 128'd0);
    end else begin
      chk("pvld", {127'd0, pvld}, {127'd0, mq.size() != 0});
      chk("bawt", {127'd0, bawt}, {127'd0, mq.size() < 2});
      chk("wen_comp", {127'd0, wen_comp}, {127'd0, !oswt || mq.size() < 2});
      if (mq.size() != 0) chk("pd", pd, mq[0]);
`ifdef SDP_Y_CHN_OUT_STALL_CNT_EN
      chk("stall_cnt", {96'd0, stall_cnt}, {96'd0, m_stall[31:0]});
`endif
    end
  end

  task automatic set_in(input logic o, input logic [127:0] d, input logic r);
    oswt = o; din = d; prdy = r;
  endtask
  task automatic to_neg();  @(negedge clk); #1; endtask
  task automatic to_edge(); @(posedge clk); #2; endtask

  logic [127:0] a5, w[10];

  initial begin
    a5 = {16{8'hA5}};
    rstn = 1'b0;
    set_in(0, '0, 0);
    to_edge(); to_edge();
    to_neg();
    chk("lit_rst_wen_comp", {127'd0, wen_comp}, 128'd1);
    to_edge();
    rstn = 1'b1;

    // Single word with prdy high.
    set_in(1, a5, 1); to_edge();
    set_in(0, '0, 1); to_neg();
    chk("lit_a5_pvld", {127'd0, pvld}, 128'd1);
    chk("lit_a5_pd", pd, a5);
    to_edge(); to_neg();
    chk("lit_a5_drained", {127'd0, pvld}, 128'd0);
    to_edge();

    // Back-pressure: 1 and 2 accepted, 3 held off while full.
    set_in(1, 128'd1, 0); to_edge();
    set_in(1, 128'd2, 0); to_edge();
    set_in(1, 128'd3, 0); to_neg();
    chk("lit_full_bawt", {127'd0, bawt}, 128'd0);
    chk("lit_full_wen", {127'd0, wen_comp}, 128'd0);
    to_edge();
    // Pop while full: offered word not taken this cycle.
    set_in(1, 128'd3, 1); to_neg();
    chk("lit_pop_full_pd", pd, 128'd1);
    chk("lit_pop_full_bawt", {127'd0, bawt}, 128'd0);
    to_edge();
    set_in(1, 128'd3, 1); to_neg();
    chk("lit_next_pd", pd, 128'd2);
    chk("lit_next_bawt", {127'd0, bawt}, 128'd1);
    to_edge();
    set_in(0, '0, 1); to_neg();
    chk("lit_third_pd", pd, 128'd3);
    to_edge(); to_edge();

    // Streaming: one word per cycle across pointer wraps.
    for (int i = 0; i < 10; i++) w[i] = {$urandom, $urandom, $urandom, $urandom};
    set_in(1, w[0], 1); to_edge();
    for (int i = 1; i < 10; i++) begin
      set_in(1, w[i], 1); to_neg();
      chk("lit_stream_pd", pd, w[i-1]);
      chk("lit_stream_bawt", {127'd0, bawt}, 128'd1);
      to_edge();
    end
    set_in(0, '0, 1); to_neg();
    chk("lit_stream_last", pd, w[9]);
    to_edge();

    // Asynchronous reset while full.
    set_in(1, 128'h11, 0); to_edge();
    set_in(1, 128'h22, 0); to_edge();
    set_in(0, '0, 0); to_neg();
    chk("lit_pre_rst_bawt", {127'd0, bawt}, 128'd0);
    rstn = 1'b0; #1;
    chk("lit_async_pvld", {127'd0, pvld}, 128'd0);
    chk("lit_async_pd", pd, 128'd0);
    chk("lit_async_bawt", {127'd0, bawt}, 128'd1);
    to_edge();
    rstn = 1'b1;
    set_in(1, 128'h77, 0); to_edge();
    for (int i = 0; i < 5; i++) begin
      set_in(0, '0, 0); to_neg();
      chk("lit_77_pd", pd, 128'h77);
      to_edge();
    end
    set_in(0, '0, 1); to_neg();
`ifdef SDP_Y_CHN_OUT_STALL_CNT_EN
    chk("lit_stall5", {96'd0, stall_cnt}, 128'd5);
`endif
    chk("lit_77_first", pd, 128'h77);
    to_edge();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom % 4) != 0, {$urandom, $urandom, $urandom, $urandom}, ($urandom % 3) != 0);
      if (i % 150 == 149) begin
        rstn = 1'b0; to_edge(); rstn = 1'b1;
      end
      to_edge();
    end
    set_in(0, '0, 1);
    to_edge(); to_edge(); to_edge();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
